// File: rtl/sixtyfour_row_feeder_pkg.sv
// rtl/sixtyfour_row_feeder_pkg.sv - shared types and constants for the 64-wide row feeder
// Contents:
//   feeder_state_t  3-bit FSM state encoding
//   count_width()   width of the per-row chunk counter (holds 0..max_chunks+1)
//   FP32_ONE        IEEE-754 single-precision 1.0, used by benches to build rows
package sixtyfour_row_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR      = 3'd1,
        ST_LOAD       = 3'd2,
        ST_FIRE       = 3'd3,
        ST_WAIT_TREE  = 3'd4,
        ST_WAIT_FINAL = 3'd5,
        ST_DONE       = 3'd6
    } feeder_state_t;

    localparam logic [31:0] FP32_ONE = 32'h3F80_0000;

    function automatic int count_width(input int max_chunks);
        return $clog2(max_chunks) + 1;
    endfunction

endpackage

// File: rtl/sixtyfour_row_feeder_watchdog.sv
// rtl/sixtyfour_row_feeder_watchdog.sv - saturating wait-cycle counter for organizer responses
// Ports:
//   clk        in   clock
//   rst        in   async active-high reset (already synchronised on deassertion)
//   i_clear    in   force the count back to zero
//   i_enable   in   count this cycle (feeder is waiting on the organizer)
//   o_expired  out  count has reached timeout_cycles-1, i.e. this is the last allowed wait cycle
module sixtyfour_row_feeder_watchdog #(
    parameter int timeout_cycles = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(timeout_cycles) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(timeout_cycles - 1);

    logic [CNT_W-1:0] r_count;

    // Count starts at 0 in the first wait cycle, so expiry lands on wait cycle
    // number timeout_cycles. Stops at the limit rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST_CNT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == LAST_CNT);

endmodule

// File: rtl/sixtyfour_row_feeder.sv
// rtl/sixtyfour_row_feeder.sv - feeds arbitrary-length rows to the 64-wide organizer in 64-element chunks
// Ports:
//   clk, main_reset                       clock, async active-high reset
//   chunk_in/chunk_valid/chunk_last       upstream chunk stream, chunk_ready back-pressure
//   adder_row_input                       chunk held for the organizer
//   outsider4, start, org_reset           organizer go pulse, row-active level, organizer clear pulse
//   ExE_finish, final_adder_finish_dash   organizer tree-done / final-accumulate-done
//   adder_output                          organizer accumulated scalar
//   result/result_valid/result_ready      row result to upstream, held until accepted
//   chunk_count                           chunks issued in the current or most recent row
//   error                                 one-cycle pulse on overflow or watchdog abort
module sixtyfour_row_feeder
    import sixtyfour_row_feeder_pkg::*;
#(
    parameter int element_width  = 32,
    parameter int no_of_units    = 64,
    parameter int max_chunks     = 16,
    parameter int timeout_cycles = 1024
) (
    input  logic                                   clk,
    input  logic                                   main_reset,
    input  logic [no_of_units*element_width-1:0]   chunk_in,
    input  logic                                   chunk_valid,
    input  logic                                   chunk_last,
    output logic                                   chunk_ready,
    output logic [no_of_units*element_width-1:0]   adder_row_input,
    output logic                                   outsider4,
    output logic                                   start,
    output logic                                   org_reset,
    input  logic                                   ExE_finish,
    input  logic                                   final_adder_finish_dash,
    input  logic [element_width-1:0]              adder_output,
    output logic [element_width-1:0]              result,
    output logic                                   result_valid,
    input  logic                                   result_ready,
    output logic [count_width(max_chunks)-1:0]    chunk_count,
    output logic                                   error
);

    localparam int CW = count_width(max_chunks);
    localparam int DW = no_of_units * element_width;
    localparam logic [CW-1:0] MAX_CNT = CW'(max_chunks);

    // Reset asserts immediately, releases two clocks after main_reset falls.
    logic r_rst_meta;
    logic r_rst;

    always_ff @(posedge clk or posedge main_reset) begin
        if (main_reset) begin
            r_rst_meta <= 1'b1;
            r_rst      <= 1'b1;
        end else begin
            r_rst_meta <= 1'b0;
            r_rst      <= r_rst_meta;
        end
    end

    feeder_state_t     r_state;
    logic [DW-1:0]     r_row_data;
    logic              r_last;
    logic [CW-1:0]     r_count;
    logic              r_outsider4;
    logic              r_start;
    logic              r_org_reset;
    logic [element_width-1:0] r_result;
    logic              r_result_valid;
    logic              r_error;

    logic w_waiting;
    logic w_wd_clear;
    logic w_expired;

    assign w_waiting  = (r_state == ST_WAIT_TREE) || (r_state == ST_WAIT_FINAL);
    // Re-arm on every entry into a wait state, including the tree -> final hop.
    assign w_wd_clear = !w_waiting || ((r_state == ST_WAIT_TREE) && ExE_finish);

    sixtyfour_row_feeder_watchdog #(
        .timeout_cycles(timeout_cycles)
    ) u_watchdog (
        .clk       (clk),
        .rst       (r_rst),
        .i_clear   (w_wd_clear),
        .i_enable  (w_waiting),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge r_rst) begin
        if (r_rst) begin
            r_state        <= ST_IDLE;
            r_row_data     <= '0;
            r_last         <= 1'b0;
            r_count        <= '0;
            r_outsider4    <= 1'b0;
            r_start        <= 1'b0;
            r_org_reset    <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_outsider4 <= 1'b0;
            r_org_reset <= 1'b0;
            r_error     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // First chunk stays pending; it is taken in LOAD after the organizer clear.
                    if (chunk_valid) begin
                        r_org_reset <= 1'b1;
                        r_count     <= '0;
                        r_state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_start <= 1'b1;
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (chunk_valid) begin
                        if (r_count == MAX_CNT) begin
                            // One chunk too many: swallow it and abandon the row.
                            r_error     <= 1'b1;
                            r_org_reset <= 1'b1;
                            r_start     <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_row_data  <= chunk_in;
                            r_last      <= chunk_last;
                            r_count     <= r_count + CW'(1);
                            r_outsider4 <= 1'b1;
                            r_state     <= ST_FIRE;
                        end
                    end
                end
                ST_FIRE: begin
                    r_state <= ST_WAIT_TREE;
                end
                ST_WAIT_TREE: begin
                    if (ExE_finish) begin
                        r_state <= r_last ? ST_WAIT_FINAL : ST_LOAD;
                    end else if (w_expired) begin
                        r_error     <= 1'b1;
                        r_org_reset <= 1'b1;
                        r_start     <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_WAIT_FINAL: begin
                    if (final_adder_finish_dash) begin
                        r_result       <= adder_output;
                        r_result_valid <= 1'b1;
                        r_start        <= 1'b0;
                        r_state        <= ST_DONE;
                    end else if (w_expired) begin
                        r_error     <= 1'b1;
                        r_org_reset <= 1'b1;
                        r_start     <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign chunk_ready     = (r_state == ST_LOAD);
    assign adder_row_input = r_row_data;
    assign outsider4       = r_outsider4;
    assign start           = r_start;
    assign org_reset       = r_org_reset;
    assign result          = r_result;
    assign result_valid    = r_result_valid;
    assign chunk_count     = r_count;
    assign error           = r_error;

endmodule

// File: tb/tb_sixtyfour_row_feeder.sv
// tb/tb_sixtyfour_row_feeder.sv - randomized self-checking bench with behavioural organizer model
module tb_sixtyfour_row_feeder;

    localparam int EW = 32;
    localparam int NU = 64;
    localparam int MC = 16;
    localparam int TO = 1024;
    localparam int DW = EW * NU;
    localparam int CW = $clog2(MC) + 1;

    logic          clk = 1'b0;
    logic          main_reset = 1'b0;
    logic [DW-1:0] chunk_in = '0;
    logic          chunk_valid = 1'b0;
    logic          chunk_last = 1'b0;
    logic          chunk_ready;
    logic [DW-1:0] adder_row_input;
    logic          outsider4;
    logic          start;
    logic          org_reset;
    logic          ExE_finish;
    logic          final_adder_finish_dash;
    logic [EW-1:0] adder_output;
    logic [EW-1:0] result;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [CW-1:0] chunk_count;
    logic          error;

    always #5 clk = ~clk;

    sixtyfour_row_feeder #(
        .element_width(EW), .no_of_units(NU), .max_chunks(MC), .timeout_cycles(TO)
    ) dut (
        .clk(clk), .main_reset(main_reset),
        .chunk_in(chunk_in), .chunk_valid(chunk_valid), .chunk_last(chunk_last),
        .chunk_ready(chunk_ready), .adder_row_input(adder_row_input),
        .outsider4(outsider4), .start(start), .org_reset(org_reset),
        .ExE_finish(ExE_finish), .final_adder_finish_dash(final_adder_finish_dash),
        .adder_output(adder_output), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .chunk_count(chunk_count), .error(error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Small non-negative integers <-> FP32 (exact for values below 2^24).
    function automatic logic [31:0] int_to_fp32(input int unsigned v);
        int e;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 32; i++) if (v[i]) e = i;
        m = (v << (23 - e)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic int unsigned fp32_to_int(input logic [31:0] f);
        int e;
        logic [31:0] m;
        if (f[30:23] == 8'd0) return 0;
        e = int'(f[30:23]) - 127;
        m = {8'd0, 1'b1, f[22:0]};
        return m >> (23 - e);
    endfunction

    function automatic int unsigned chunk_sum(input logic [DW-1:0] d);
        int unsigned s = 0;
        for (int i = 0; i < NU; i++) s += fp32_to_int(d[i*EW +: EW]);
        return s;
    endfunction

    // Organizer model: tree done ~7 cycles after go, final done 4 cycles after tree done.
    logic        no_exe = 1'b0;
    int unsigned acc;
    int          tree_cnt;
    int          fin_cnt;

    always @(posedge clk or posedge main_reset) begin
        if (main_reset) begin
            acc <= 0; tree_cnt <= 0; fin_cnt <= 0;
            ExE_finish <= 1'b0; final_adder_finish_dash <= 1'b0;
        end else begin
            ExE_finish <= 1'b0;
            final_adder_finish_dash <= 1'b0;
            if (org_reset) begin
                acc <= 0; tree_cnt <= 0; fin_cnt <= 0;
            end else begin
                if (outsider4) begin
                    acc <= acc + chunk_sum(adder_row_input);
                    tree_cnt <= 7;
                end else if (tree_cnt != 0) begin
                    tree_cnt <= tree_cnt - 1;
                    if (tree_cnt == 1 && !no_exe) ExE_finish <= 1'b1;
                end
                if (ExE_finish) begin
                    fin_cnt <= 4;
                end else if (fin_cnt != 0) begin
                    fin_cnt <= fin_cnt - 1;
                    if (fin_cnt == 1) final_adder_finish_dash <= 1'b1;
                end
            end
        end
    end

    assign adder_output = int_to_fp32(acc);

    // Event monitor, sampled mid-cycle.
    int cyc = 0;
    int n_fire = 0, n_err = 0, n_orst = 0, n_rv = 0, bad_start = 0;
    logic prev_rv = 1'b0;
    int fire_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (outsider4) begin
            n_fire++;
            fire_q.push_back(cyc);
            if (!start) bad_start++;
        end
        if (error) n_err++;
        if (org_reset) n_orst++;
        if (result_valid && !prev_rv) n_rv++;
        prev_rv = result_valid;
    end

    task automatic make_chunk(input bit ones, output logic [DW-1:0] d, output int unsigned s);
        int unsigned v;
        s = 0;
        for (int i = 0; i < NU; i++) begin
            v = ones ? 1 : $urandom_range(255, 0);
            d[i*EW +: EW] = int_to_fp32(v);
            s += v;
        end
    endtask

    // stall > 0: let the feeder sit in LOAD with no valid for that many cycles first.
    task automatic send_chunk(input logic [DW-1:0] d, input logic last, input int stall);
        int t;
        if (stall > 0) begin
            chunk_valid = 1'b0;
            for (t = 0; t < 200 && !chunk_ready; t++) @(negedge clk);
            for (int k = 0; k < stall; k++) begin
                check("stall_ready", chunk_ready, 1);
                check("stall_go", outsider4, 0);
                check("stall_start", start, 1);
                @(negedge clk);
            end
        end
        chunk_in = d;
        chunk_last = last;
        chunk_valid = 1'b1;
        for (t = 0; t < 3000 && !chunk_ready; t++) @(negedge clk);
        check("hs_ready", chunk_ready, 1);
        @(posedge clk);
        #1;
        chunk_valid = 1'b0;
        chunk_last = 1'b0;
        @(negedge clk);
    endtask

    logic [EW-1:0] last_result;

    task automatic run_row(input string tag, input int n, input int st_lo, input int st_hi,
                           input bit ones, input int hold);
        logic [DW-1:0] d;
        int unsigned s, total;
        int f0, bs0, g, t;
        fire_q.delete();
        f0 = n_fire;
        bs0 = bad_start;
        total = 0;
        for (int k = 0; k < n; k++) begin
            make_chunk(ones, d, s);
            total += s;
            send_chunk(d, (k == n - 1), (k == 0) ? 0 : int'($urandom_range(st_hi, st_lo)));
        end
        for (t = 0; t < 400 && !result_valid; t++) @(negedge clk);
        check({tag, "_rv"}, result_valid, 1);
        check({tag, "_result"}, result, int_to_fp32(total));
        last_result = result;
        check({tag, "_count"}, chunk_count, n);
        check({tag, "_fires"}, n_fire - f0, n);
        check({tag, "_start_at_go"}, bad_start - bs0, 0);
        check({tag, "_start_done"}, start, 0);
        if (n > 1) begin
            g = 1000;
            for (int i = 1; i < fire_q.size(); i++)
                if (fire_q[i] - fire_q[i-1] < g) g = fire_q[i] - fire_q[i-1];
            check({tag, "_gap_ge9"}, (g >= 9), 1);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_rv"}, result_valid, 1);
            check({tag, "_hold_res"}, result, int_to_fp32(total));
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check({tag, "_rv_clr"}, result_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, chunk_ready, 0);
        check({tag, "_row"}, (adder_row_input == '0), 1);
        check({tag, "_go"}, outsider4, 0);
        check({tag, "_start"}, start, 0);
        check({tag, "_orst"}, org_reset, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_rv"}, result_valid, 0);
        check({tag, "_count"}, chunk_count, 0);
        check({tag, "_err"}, error, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, got %0d cycles", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [DW-1:0] d;
        int unsigned s;
        int e0, o0, r0, t, delta;

        #2 main_reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        main_reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single chunk of 1.0s, result held while upstream stalls.
        run_row("single", 1, 0, 0, 1'b1, 10);
        check("single_const", last_result, 32'h4280_0000);

        // Four chunks back-to-back.
        run_row("four", 4, 0, 0, 1'b0, 0);

        // Two chunks with a five-cycle valid gap in LOAD.
        run_row("gap5", 2, 5, 5, 1'b0, 0);

        // Random rows.
        for (int r = 0; r < 5; r++)
            run_row("rand", int'($urandom_range(MC, 1)), 0, 3, 1'b0, int'($urandom_range(3, 0)));

        // Overflow: 17 chunks with no last.
        e0 = n_err; o0 = n_orst; r0 = n_rv;
        for (int k = 0; k < MC; k++) begin
            make_chunk(1'b0, d, s);
            send_chunk(d, 1'b0, 0);
        end
        make_chunk(1'b0, d, s);
        send_chunk(d, 1'b0, 0);
        check("ovf_err_pulse", error, 1);
        check("ovf_orst_pulse", org_reset, 1);
        check("ovf_start", start, 0);
        repeat (20) @(negedge clk);
        check("ovf_err_cnt", n_err - e0, 1);
        check("ovf_orst_cnt", n_orst - o0, 2);
        check("ovf_no_result", n_rv - r0, 0);
        check("ovf_idle", chunk_ready, 0);

        // Watchdog: tree-done never arrives.
        no_exe = 1'b1;
        e0 = n_err; r0 = n_rv;
        fire_q.delete();
        make_chunk(1'b0, d, s);
        send_chunk(d, 1'b0, 0);
        for (t = 0; t < 1200 && !error; t++) @(negedge clk);
        check("wd_err", error, 1);
        delta = (fire_q.size() > 0) ? cyc - fire_q[0] : 0;
        check("wd_delay_window", (delta >= TO && delta <= TO + 2), 1);
        check("wd_start", start, 0);
        repeat (5) @(negedge clk);
        check("wd_err_cnt", n_err - e0, 1);
        check("wd_no_result", n_rv - r0, 0);
        check("wd_idle", chunk_ready, 0);
        no_exe = 1'b0;

        // Recovery row after the abort.
        run_row("after_wd", 3, 0, 2, 1'b0, 0);

        // Async reset while waiting on the tree.
        no_exe = 1'b1;
        r0 = n_rv;
        make_chunk(1'b0, d, s);
        send_chunk(d, 1'b1, 0);
        repeat (3) @(negedge clk);
        check("pre_rst_start", start, 1);
        #2 main_reset = 1'b1;
        #1 check_all_zero("mid_rst");
        @(negedge clk);
        main_reset = 1'b0;
        no_exe = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_rst_no_result", n_rv - r0, 0);
        check("mid_rst_start", start, 0);

        run_row("after_rst", 2, 0, 1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
